// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter and instruction fetch sequencer
module pc_sequencer #(
    parameter int           N        = 32,
    parameter logic [N-1:0] RESET_PC = '0,
    parameter int           MAX_WAIT = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] PCPlus4,
    input  logic [N-1:0] PCTarget,
    input  logic [25:0]  JumpIndex,
    input  logic [N-1:0] RegTarget,
    input  logic [1:0]   PCSrc,
    input  logic         stall,
    input  logic         imem_ack,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    output logic [N-1:0] PC,
    output logic         instr_valid,
    output logic         fetch_error
);

    localparam int           CW    = $clog2(MAX_WAIT + 1);
    localparam logic [CW:0]  MAX_W = (CW + 1)'(MAX_WAIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_EXEC,
        S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  pc_q, pc_d;
    logic [N-1:0]  next_pc;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW:0]   cnt_inc;

    // Next-PC candidate; only consumed on a non-stalled EXEC edge
    always_comb begin
        next_pc = PCPlus4;
        case (PCSrc)
            2'b00:   next_pc = PCPlus4;
            2'b01:   next_pc = PCTarget;
            2'b10:   next_pc = {PCPlus4[N-1:28], JumpIndex, 2'b00};
            default: next_pc = RegTarget;
        endcase
    end

    // One extra bit so the increment cannot wrap before the compare
    assign cnt_inc = {1'b0, cnt_q} + 1'b1;

    // State, PC and wait-counter registers; reset abandons any fetch in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sequencing: request, wait for ack with timeout, execute, advance or fault
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (imem_ack) begin
                    state_d = S_EXEC;
                    cnt_d   = '0;
                end else if (cnt_inc >= MAX_W) begin
                    state_d = S_ERR;
                    cnt_d   = MAX_W[CW-1:0];
                end else begin
                    cnt_d = cnt_inc[CW-1:0];
                end
            end
            S_EXEC: begin
                if (!stall) begin
                    if (next_pc[1:0] == 2'b00) begin
                        pc_d    = next_pc;
                        state_d = S_REQ;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            default: begin
                state_d = S_ERR;
            end
        endcase
    end

    // Outputs decode from state and PC only, never from imem_ack
    assign imem_req    = (state_q == S_REQ);
    assign instr_valid = (state_q == S_EXEC);
    assign fetch_error = (state_q == S_ERR);
    assign imem_addr   = pc_q;
    assign PC          = pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer with random fetch traffic
module tb_pc_sequencer;

    localparam int          MAX_WAIT = 15;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] PCPlus4 = '0;
    logic [31:0] PCTarget = '0;
    logic [25:0] JumpIndex = '0;
    logic [31:0] RegTarget = '0;
    logic [1:0]  PCSrc = '0;
    logic        stall = 1'b0;
    logic        imem_ack = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] PC;
    logic        instr_valid;
    logic        fetch_error;

    pc_sequencer #(
        .N        (32),
        .RESET_PC (RST_PC),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .PCPlus4     (PCPlus4),
        .PCTarget    (PCTarget),
        .JumpIndex   (JumpIndex),
        .RegTarget   (RegTarget),
        .PCSrc       (PCSrc),
        .stall       (stall),
        .imem_ack    (imem_ack),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .PC          (PC),
        .instr_valid (instr_valid),
        .fetch_error (fetch_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [31:0] addr;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] m_pc = RST_PC;
    bit          prev_req = 1'b0;
    bit          prev_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic scramble();
        PCSrc     = 2'($urandom);
        PCPlus4   = $urandom;
        PCTarget  = $urandom;
        JumpIndex = 26'($urandom);
        RegTarget = $urandom;
    endtask

    // Monitor: every new request and every new error must match the scoreboard head
    always @(negedge clk) begin
        if (reset) begin
            prev_req = 1'b0;
            prev_err = 1'b0;
        end else begin
            chk("addr_eq_pc", imem_addr, PC);
            chk("req_valid_excl", 32'(imem_req & instr_valid), 32'd0);
            if (imem_req && !prev_req) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_fetch_unexpected: got fetch %h expected none", imem_addr);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sb_fetch_kind", 32'(mon_e.is_err), 32'd0);
                    chk("sb_fetch_addr", imem_addr, mon_e.addr);
                end
            end
            if (fetch_error && !prev_err) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_err_unexpected: got error at %h expected none", PC);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sb_err_kind", 32'(mon_e.is_err), 32'd1);
                    chk("sb_err_pc", PC, mon_e.addr);
                end
            end
            prev_req = imem_req;
            prev_err = fetch_error;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        imem_ack = 1'b0;
        stall    = 1'b0;
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_err", 32'(fetch_error), 32'd0);
        chk("rst_pc", PC, RST_PC);
        exp_q.delete();
        m_pc = RST_PC;
        @(negedge clk);
        @(negedge clk);
        exp_q.push_back('{1'b0, RST_PC});
        reset = 1'b0;
    endtask

    task automatic wait_req();
        int t = 0;
        while (!imem_req && t < 20) begin
            scramble();
            @(negedge clk);
            t++;
        end
        chk("req_seen", 32'(imem_req), 32'd1);
    endtask

    // One instruction: fetch with `delay` un-acked cycles, `stalls` stalled EXEC cycles,
    // then retire choosing kind 0 seq / 1 branch / 2 jump / 3 jr
    task automatic run_instr(input int delay, input int stalls, input int kind,
                             input logic [31:0] p4, input logic [31:0] val,
                             input logic [25:0] idx, output bit err);
        logic [31:0] nxt;
        err = 1'b0;
        wait_req();
        chk("req_pc", PC, m_pc);
        for (int i = 0; i < delay; i++) begin
            imem_ack = 1'b0;
            scramble();
            @(negedge clk);
            chk("req_hold", 32'(imem_req), 32'd1);
            chk("req_addr_stable", imem_addr, m_pc);
        end
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("exec_valid", 32'(instr_valid), 32'd1);
        chk("exec_req", 32'(imem_req), 32'd0);
        for (int s = 0; s < stalls; s++) begin
            stall = 1'b1;
            scramble();
            @(negedge clk);
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_req", 32'(imem_req), 32'd0);
            chk("stall_pc", PC, m_pc);
        end
        stall     = 1'b0;
        scramble();
        PCSrc     = 2'(kind);
        PCPlus4   = p4;
        if (kind == 1) PCTarget = val;
        if (kind == 3) RegTarget = val;
        JumpIndex = idx;
        case (kind)
            0:       nxt = p4;
            1:       nxt = val;
            2:       nxt = (p4 & 32'hF000_0000) | (32'(idx) * 4);
            default: nxt = val;
        endcase
        if (nxt % 4 == 0) begin
            exp_q.push_back('{1'b0, nxt});
            m_pc = nxt;
        end else begin
            exp_q.push_back('{1'b1, m_pc});
            err = 1'b1;
        end
        @(negedge clk);
        scramble();
        if (err) begin
            chk("misalign_err", 32'(fetch_error), 32'd1);
            chk("misalign_pc", PC, m_pc);
            chk("misalign_req", 32'(imem_req), 32'd0);
        end else begin
            chk("retire_req", 32'(imem_req), 32'd1);
            chk("retire_pc", PC, m_pc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bit          err;
        int          kind;
        int          r;
        logic [31:0] val;

        do_reset();
        // sequential fetch with a 3-cycle stall at 0x8
        run_instr(0, 0, 0, m_pc + 4, 0, 0, err);
        run_instr(0, 0, 0, m_pc + 4, 0, 0, err);
        run_instr(0, 3, 0, m_pc + 4, 0, 0, err);
        chk("after_stall_pc", PC, 32'h0000_000C);
        run_instr(0, 0, 0, m_pc + 4, 0, 0, err);
        chk("pc_0x10", PC, 32'h0000_0010);
        // branch and jump
        run_instr(0, 0, 1, m_pc + 4, 32'h0000_0040, 0, err);
        chk("branch_pc", PC, 32'h0000_0040);
        run_instr(0, 0, 2, 32'h1000_0014, 0, 26'h0000100, err);
        chk("jump_pc", PC, 32'h1000_0400);
        // wrap-around PCPlus4 and delayed ack
        run_instr(0, 0, 3, m_pc + 4, 32'hFFFF_FFFC, 0, err);
        run_instr(5, 0, 0, m_pc + 4, 0, 0, err);
        chk("wrap_pc", PC, 32'h0000_0000);
        run_instr(2, 1, 0, m_pc + 4, 0, 0, err);
        // misaligned jr
        run_instr(0, 0, 3, m_pc + 4, 32'h0000_0022, 0, err);
        chk("jr22_err", 32'(err), 32'd1);
        imem_ack = 1'b1;
        repeat (3) @(negedge clk);
        chk("jr22_sticky", 32'(fetch_error), 32'd1);
        imem_ack = 1'b0;

        // timeout after exactly MAX_WAIT un-acked REQ cycles, late ack ignored
        do_reset();
        wait_req();
        exp_q.push_back('{1'b1, m_pc});
        for (int i = 0; i < MAX_WAIT; i++) begin
            chk("to_req", 32'(imem_req), 32'd1);
            chk("to_noerr", 32'(fetch_error), 32'd0);
            scramble();
            @(negedge clk);
        end
        chk("to_err", 32'(fetch_error), 32'd1);
        chk("to_req_low", 32'(imem_req), 32'd0);
        imem_ack = 1'b1;
        repeat (3) @(negedge clk);
        imem_ack = 1'b0;
        chk("to_sticky", 32'(fetch_error), 32'd1);
        chk("to_late_valid", 32'(instr_valid), 32'd0);

        // asynchronous reset in the middle of a REQ cycle
        do_reset();
        run_instr(0, 0, 0, m_pc + 4, 0, 0, err);
        #2 reset = 1'b1;
        #1;
        chk("async_req", 32'(imem_req), 32'd0);
        chk("async_pc", PC, RST_PC);
        chk("async_valid", 32'(instr_valid), 32'd0);
        chk("async_err", 32'(fetch_error), 32'd0);
        do_reset();

        // random traffic
        for (int n = 0; n < 150; n++) begin
            r    = $urandom_range(0, 9);
            kind = (r < 4) ? 0 : (r < 6) ? 1 : (r == 6) ? 2 : (r == 7) ? 3 : 0;
            val  = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 15) == 0) val = 32'hFFFF_FFFC;
            if (r == 8) begin
                kind = 1 + 2 * $urandom_range(0, 1);
                val  = val | 32'($urandom_range(1, 3));
            end
            run_instr($urandom_range(0, MAX_WAIT - 2), $urandom_range(0, 3), kind,
                      m_pc + 4, val, 26'($urandom), err);
            if (err) do_reset();
        end
        wait_req();
        @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
